io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO path.
- Decodes the IO read/write strobes and the 14-bit IO address driven by the CPU's memory/IO steering logic.
- Returns 16-bit switch data on reads and latches LED and seven-segment writes.
- Debounces the physical confirm button and presents a sticky confirm flag that the CPU polls at address 0x3c80.

Parameters:
DEB_CYCLES, 20'd1000000, consecutive stable cycles required before the debounced button level changes (use 4 in simulation)
CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEB_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ioRead_i  input  1  IO read strobe from CPU side
ioWrite_i  input  1  IO write strobe from CPU side
addr_i  input  14  IO address
wdata_i  input  32  write data from CPU side
sw_i  input  16  board switches (asynchronous)
btn_confirm_i  input  1  raw confirm button, active-high, bouncing
io_rdata_o  output  16  read data to CPU side
confirm_o  output  1  sticky confirm flag to CPU side
led_o  output  16  LED register
seg_o  output  32  seven-segment data register (8 hex digits)

Behaviour:
- Clock and reset: one clock domain; asynchronous, active-low reset; all flops clear on rst_n=0 regardless of clk.
- Reset values: led_o=0, seg_o=0, confirm_o=0, sw_q=0, debounced level=0, debounce counter=0.
- Address map (exact 14-bit match; other addresses are ignored on write and return 0 on read):
  - 0x3c00: switch read
  - 0x3c40: LED write
  - 0x3c60: seg write
  - 0x3c80: confirm status
- Switch sampling: sw_q <= sw_i every cycle.
- io_rdata_o: combinational.
  - Returns sw_q when ioRead_i=1 and addr_i=0x3c00.
  - Returns 0 otherwise, including for 0x3c80; the confirm value reaches the CPU via confirm_o.
- Writes:
  - ioWrite_i=1 with addr 0x3c40: led_o <= wdata_i[15:0] at the next rising edge.
  - ioWrite_i=1 with addr 0x3c60: seg_o <= wdata_i at the next rising edge.
  - ioWrite_i=1 with addr 0x3c00 or 0x3c80: no effect.
- Simultaneous ioRead_i and ioWrite_i: both actions are performed; the write does not affect the same-cycle read value.
- Debounce FSM, states STABLE and COUNT:
  - STABLE: if raw != debounced level, go to COUNT with counter=1.
  - COUNT: if raw == debounced level, return to STABLE and clear the counter.
  - COUNT: else if counter == DEB_CYCLES-1, flip the debounced level, go to STABLE, clear the counter.
  - COUNT: else increment the counter.
  - Net effect: the debounced level changes exactly DEB_CYCLES cycles after raw first differs, provided raw stays stable; any bounce restarts the count.
- Confirm flag:
  - Set the cycle after a rising edge of the debounced level.
  - Cleared (read-to-clear) at the edge following a cycle with ioRead_i=1, addr_i=0x3c80 and confirm_o=1.
  - If set and clear occur in the same cycle, set wins.
  - Falling edges of the debounced level do not affect the flag.
- Reset mid-debounce abandons the count; the FSM restarts in STABLE with debounced level 0.
- Counter never wraps; it saturates logically because the FSM leaves COUNT at DEB_CYCLES-1.

Optional Feature:
- Macro IO_READBACK_EN.
- Defined:
  - ioRead_i at 0x3c40 returns led_o.
  - ioRead_i at 0x3c60 returns seg_o[15:0].
  - ioRead_i at 0x3c80 returns {15'b0, confirm_o}.
- Undefined: those addresses read 0 as described in Behaviour.
- Write behaviour and confirm read-to-clear are identical in both builds.

Test Plan (DEB_CYCLES=4):
1. Reset and switch read: assert rst_n=0 mid-cycle -> all outputs are 0 immediately, asynchronously. Then set sw_i=16'hA5C3 and wait 1 cycle; ioRead_i=1, addr 0x3c00 -> io_rdata_o=16'hA5C3. Same stimulus at addr 0x3c04 -> io_rdata_o=0.
2. Writes: ioWrite_i=1, addr 0x3c40, wdata 32'h1234BEEF -> led_o=16'hBEEF next edge. Addr 0x3c60, wdata 32'hDEADBEEF -> seg_o=32'hDEADBEEF. Addr 0x3c80 write -> no output change.
3. Bounced press: btn toggles 1,0,1,0 over 4 cycles, then held at 1 -> confirm_o rises exactly 4 cycles after the final 0->1 plus 1 cycle. No assertion occurs during the bounce.
4. Read-to-clear: with confirm_o=1, ioRead_i=1 at addr 0x3c80 for one cycle -> confirm_o=0 next edge. Button still held -> flag stays 0. Release and press cleanly again -> flag sets again.
5. Set/clear collision: align the debounced rising edge with a 0x3c80 read cycle -> confirm_o remains 1.
6. Reset mid-debounce: raw button goes 1, reset pulse after 2 cycles, button still held -> after release of reset, confirm_o rises only after a full 4 stable cycles plus 1.

Source files
------------

// File: rtl/io_responder.sv
// Memory-mapped IO responder: switch readback, LED/seven-segment write latches and a
// debounced, sticky read-to-clear confirm flag. Define IO_READBACK_EN to read back LED/seg/confirm.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_STABLE  | raw button matches debounced level; counter idle at 0
// ST_COUNT   | raw differs from debounced level; counting consecutive cycles
module io_responder #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int          CNT_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ioRead_i,
    input  logic        ioWrite_i,
    input  logic [13:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] sw_i,
    input  logic        btn_confirm_i,
    output logic [15:0] io_rdata_o,
    output logic        confirm_o,
    output logic [15:0] led_o,
    output logic [31:0] seg_o
);

    localparam logic [13:0] ADDR_SW      = 14'h3c00;
    localparam logic [13:0] ADDR_LED     = 14'h3c40;
    localparam logic [13:0] ADDR_SEG     = 14'h3c60;
    localparam logic [13:0] ADDR_CONFIRM = 14'h3c80;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNT
    } deb_state_t;

    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;
    logic [15:0]      sw_q;
    logic             confirm_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q  <= '0;
            led_o <= '0;
            seg_o <= '0;
        end else begin
            sw_q <= sw_i;
            if (ioWrite_i && addr_i == ADDR_LED)
                led_o <= wdata_i[15:0];
            if (ioWrite_i && addr_i == ADDR_SEG)
                seg_o <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (btn_confirm_i != level) begin
                        state <= ST_COUNT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (btn_confirm_i == level) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level <= ~level;
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign confirm_clr = ioRead_i && (addr_i == ADDR_CONFIRM) && confirm_o;

    // A new press arriving in the same cycle as the clearing read must not be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d   <= 1'b0;
            confirm_o <= 1'b0;
        end else begin
            level_d <= level;
            if (level && !level_d)
                confirm_o <= 1'b1;
            else if (confirm_clr)
                confirm_o <= 1'b0;
        end
    end

    always_comb begin
        io_rdata_o = '0;
        if (ioRead_i) begin
            case (addr_i)
                ADDR_SW:      io_rdata_o = sw_q;
`ifdef IO_READBACK_EN
                ADDR_LED:     io_rdata_o = led_o;
                ADDR_SEG:     io_rdata_o = seg_o[15:0];
                ADDR_CONFIRM: io_rdata_o = {15'b0, confirm_o};
`endif
                default:      io_rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the live outputs.
module tb_io_responder;

    logic        clk;
    logic        rst_n;
    logic        ioRead_i;
    logic        ioWrite_i;
    logic [13:0] addr_i;
    logic [31:0] wdata_i;
    logic [15:0] sw_i;
    logic        btn_confirm_i;
    logic [15:0] io_rdata_o;
    logic        confirm_o;
    logic [15:0] led_o;
    logic [31:0] seg_o;

    localparam int SEL_RDATA = 0;
    localparam int SEL_LED   = 1;
    localparam int SEL_SEG   = 2;
    localparam int SEL_CONF  = 3;

`ifdef IO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    io_responder #(.DEB_CYCLES(4), .CNT_W(20)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ioRead_i      (ioRead_i),
        .ioWrite_i     (ioWrite_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .sw_i          (sw_i),
        .btn_confirm_i (btn_confirm_i),
        .io_rdata_o    (io_rdata_o),
        .confirm_o     (confirm_o),
        .led_o         (led_o),
        .seg_o         (seg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          when;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_RDATA: return {16'b0, io_rdata_o};
            SEL_LED:   return {16'b0, led_o};
            SEL_SEG:   return seg_o;
            default:   return {31'b0, confirm_o};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            mon_e = sb.pop_front();
            act = actual(mon_e.sel);
            checks++;
            if (act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s (cycle %0d): got %h expected %h", mon_e.name, cyc, act, mon_e.exp);
            end
        end
    end

    task automatic expect_now(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.when = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ioRead_i  = 1'b0;
        ioWrite_i = 1'b0;
        addr_i    = '0;
        wdata_i   = '0;
    endtask

    task automatic hold_conf(input int n, input logic v, input string name);
        for (int i = 0; i < n; i++) begin
            step();
            expect_now(SEL_CONF, {31'b0, v}, name);
        end
    endtask

    initial begin
        logic [3:0] bounce;
        rst_n = 1'b0;
        btn_confirm_i = 1'b0;
        sw_i = 16'hFFFF;
        idle_bus();

        // reset state; sw_q must stay cleared while in reset
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c00;
        expect_now(SEL_LED,   32'h0, "rst_led");
        expect_now(SEL_SEG,   32'h0, "rst_seg");
        expect_now(SEL_CONF,  32'h0, "rst_conf");
        expect_now(SEL_RDATA, 32'h0, "rst_swq");
        step();
        rst_n = 1'b1;
        idle_bus();
        sw_i = 16'hA5C3;
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c00;
        expect_now(SEL_RDATA, 32'h0000A5C3, "sw_read");
        step();
        addr_i = 14'h3c04;
        expect_now(SEL_RDATA, 32'h0, "unmapped_read");

        // writes
        step();
        ioRead_i  = 1'b0;
        ioWrite_i = 1'b1;
        addr_i    = 14'h3c40;
        wdata_i   = 32'h1234BEEF;
        step();
        addr_i  = 14'h3c60;
        wdata_i = 32'hDEADBEEF;
        expect_now(SEL_LED, 32'h0000BEEF, "led_write");
        step();
        addr_i  = 14'h3c80;
        wdata_i = 32'hFFFFFFFF;
        expect_now(SEL_SEG, 32'hDEADBEEF, "seg_write");
        step();
        addr_i  = 14'h3c44;
        wdata_i = 32'h00000000;
        expect_now(SEL_LED, 32'h0000BEEF, "conf_write_led");
        expect_now(SEL_SEG, 32'hDEADBEEF, "conf_write_seg");
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c40;
        wdata_i  = 32'h00005A5A;
        expect_now(SEL_LED,   32'h0000BEEF, "unmapped_write_led");
        expect_now(SEL_RDATA, RB ? 32'h0000BEEF : 32'h0, "rw_same_cycle_read");
        step();
        ioWrite_i = 1'b0;
        addr_i    = 14'h3c60;
        expect_now(SEL_LED,   32'h00005A5A, "rw_same_cycle_write");
        expect_now(SEL_RDATA, RB ? 32'h0000BEEF : 32'h0, "seg_readback");

        // asynchronous reset between clock edges
        step();
        idle_bus();
        rst_n = 1'b0;
        expect_now(SEL_LED, 32'h0, "async_rst_led");
        expect_now(SEL_SEG, 32'h0, "async_rst_seg");
        step();
        rst_n = 1'b1;
        step();

        // bounced press then held
        bounce = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            btn_confirm_i = bounce[i];
            expect_now(SEL_CONF, 32'h0, "bounce_quiet");
        end
        step();
        btn_confirm_i = 1'b1;
        expect_now(SEL_CONF, 32'h0, "press_wait");
        hold_conf(4, 1'b0, "press_wait");
        hold_conf(1, 1'b1, "press_set");

        // read-to-clear
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c80;
        expect_now(SEL_CONF,  32'h1, "clr_before");
        expect_now(SEL_RDATA, RB ? 32'h1 : 32'h0, "conf_read_data");
        step();
        idle_bus();
        expect_now(SEL_CONF, 32'h0, "clr_after");
        hold_conf(3, 1'b0, "held_stays_clear");
        step();
        btn_confirm_i = 1'b0;
        expect_now(SEL_CONF, 32'h0, "release");
        hold_conf(6, 1'b0, "release_quiet");
        step();
        btn_confirm_i = 1'b1;
        expect_now(SEL_CONF, 32'h0, "repress_wait");
        hold_conf(4, 1'b0, "repress_wait");
        hold_conf(1, 1'b1, "repress_set");

        // falling edge leaves flag, then set/clear collision
        step();
        btn_confirm_i = 1'b0;
        expect_now(SEL_CONF, 32'h1, "fall_keeps");
        hold_conf(6, 1'b1, "fall_keeps");
        step();
        btn_confirm_i = 1'b1;
        expect_now(SEL_CONF, 32'h1, "coll_pre");
        hold_conf(3, 1'b1, "coll_pre");
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c80;
        expect_now(SEL_CONF, 32'h1, "coll_read_cycle");
        step();
        idle_bus();
        expect_now(SEL_CONF, 32'h1, "coll_set_wins");
        hold_conf(1, 1'b1, "coll_set_wins");
        step();
        ioRead_i = 1'b1;
        addr_i   = 14'h3c80;
        expect_now(SEL_CONF, 32'h1, "coll_clear_read");
        step();
        idle_bus();
        expect_now(SEL_CONF, 32'h0, "coll_cleared");

        // reset in the middle of a debounce count
        step();
        btn_confirm_i = 1'b0;
        expect_now(SEL_CONF, 32'h0, "pre_rst_release");
        hold_conf(6, 1'b0, "pre_rst_release");
        step();
        btn_confirm_i = 1'b1;
        expect_now(SEL_CONF, 32'h0, "mid_rst_press");
        hold_conf(1, 1'b0, "mid_rst_press");
        step();
        rst_n = 1'b0;
        expect_now(SEL_CONF, 32'h0, "mid_rst_low");
        step();
        rst_n = 1'b1;
        expect_now(SEL_CONF, 32'h0, "mid_rst_release");
        hold_conf(4, 1'b0, "mid_rst_recount");
        hold_conf(1, 1'b1, "mid_rst_set");

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
